// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types and constants for the SRAM arbiter
// Contents: SRAM geometry, timing counter width, FSM state enum, counter load helper.
package sram_arb_pkg;

   localparam int SRAM_AW = 18;
   localparam int SRAM_DW = 8;
   localparam int CNT_W   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_DONE
   } state_e;

   // Phase counters count down to zero, so a phase of N cycles loads N-1.
   function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cyc);
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - single-byte request/ack port of the SRAM arbiter
// master: requester side (drives req/we/addr/wdata, receives ack/rdata)
// slave : arbiter side
interface sram_arbiter_if;
   import sram_arb_pkg::*;

   logic               req;
   logic               we;
   logic [SRAM_AW-1:0] addr;
   logic [SRAM_DW-1:0] wdata;
   logic               ack;
   logic [SRAM_DW-1:0] rdata;

   modport master (output req, output we, output addr, output wdata,
                   input  ack, input  rdata);
   modport slave  (input  req, input  we, input  addr, input  wdata,
                   output ack, output rdata);
endinterface

// File: rtl/sram_arbiter_select.sv
// rtl/sram_arbiter_select.sv - combinational winner pick between the two requesters
// Ports: req0_i/req1_i requests, last_grant_i (SRAM_ARB_ROUND_ROBIN_EN only),
//        valid_o any request present, grant_o winning port index.
// Macro SRAM_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise port 0 wins.
module sram_arb_select (
   input  logic req0_i,
   input  logic req1_i,
`ifdef SRAM_ARB_ROUND_ROBIN_EN
   input  logic last_grant_i,
`endif
   output logic valid_o,
   output logic grant_o
);

   always_comb begin
      valid_o = req0_i | req1_i;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      if (req0_i && req1_i) begin
         grant_o = ~last_grant_i;
      end else begin
         grant_o = req1_i;
      end
`else
      grant_o = ~req0_i & req1_i;
`endif
   end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and timed access sequencer for 256K x 8 SRAM
// Ports: clk, reset_b (async, active low); p0/p1 requester ports (slave modport);
//        busy; ext_RAMCS_b/OE_b/WE_b strobes; ext_RAMA address; ext_RAMDin write
//        data; ext_RAMDout read data.
// Macro SRAM_ARB_ROUND_ROBIN_EN: round-robin on contention (default fixed priority port 0).
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned SETUP_CYC  = 1,
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned HOLD_CYC   = 1
) (
   input  logic               clk,
   input  logic               reset_b,
   sram_arbiter_if.slave      p0,
   sram_arbiter_if.slave      p1,
   output logic               busy,
   output logic               ext_RAMCS_b,
   output logic               ext_RAMOE_b,
   output logic               ext_RAMWE_b,
   output logic [SRAM_AW-1:0] ext_RAMA,
   output logic [SRAM_DW-1:0] ext_RAMDin,
   input  logic [SRAM_DW-1:0] ext_RAMDout
);

   localparam logic [CNT_W-1:0] SETUP_LD  = cnt_load(SETUP_CYC);
   localparam logic [CNT_W-1:0] STROBE_LD = cnt_load(STROBE_CYC);
   localparam logic [CNT_W-1:0] HOLD_LD   = cnt_load(HOLD_CYC);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               op_we_q, op_we_d;
   logic               win_q, win_d;
   logic [SRAM_AW-1:0] addr_q, addr_d;
   logic [SRAM_DW-1:0] din_q, din_d;
   logic [SRAM_DW-1:0] rd_q, rd_d;
   logic [SRAM_DW-1:0] rdata0_q, rdata0_d;
   logic [SRAM_DW-1:0] rdata1_q, rdata1_d;
   logic               cs_b_q, cs_b_d;
   logic               oe_b_q, oe_b_d;
   logic               we_b_q, we_b_d;
   logic               ack0_q, ack0_d;
   logic               ack1_q, ack1_d;
   logic               busy_q, busy_d;

   logic               sel_valid;
   logic               sel_grant;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic               last_grant_q;

   sram_arb_select u_select (
      .req0_i       (p0.req),
      .req1_i       (p1.req),
      .last_grant_i (last_grant_q),
      .valid_o      (sel_valid),
      .grant_o      (sel_grant)
   );

   // Reset to port 1 so the first contended grant goes to port 0.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         last_grant_q <= 1'b1;
      end else if (state_q == ST_IDLE && sel_valid) begin
         last_grant_q <= sel_grant;
      end
   end
`else
   sram_arb_select u_select (
      .req0_i  (p0.req),
      .req1_i  (p1.req),
      .valid_o (sel_valid),
      .grant_o (sel_grant)
   );
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_we_d  = op_we_q;
      win_d    = win_q;
      addr_d   = addr_q;
      din_d    = din_q;
      rd_d     = rd_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;

      unique case (state_q)
         ST_IDLE: begin
            if (sel_valid) begin
               win_d   = sel_grant;
               op_we_d = sel_grant ? p1.we    : p0.we;
               addr_d  = sel_grant ? p1.addr  : p0.addr;
               din_d   = sel_grant ? p1.wdata : p0.wdata;
               cnt_d   = SETUP_LD;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = STROBE_LD;
               state_d = ST_STROBE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == '0) begin
               // Sample the SRAM while OE_b is still low on the last strobe cycle.
               if (!op_we_q) begin
                  rd_d = ext_RAMDout;
               end
               cnt_d   = HOLD_LD;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               // Publish read data on the same edge that raises ack.
               if (!op_we_q) begin
                  if (win_q) begin
                     rdata1_d = rd_q;
                  end else begin
                     rdata0_d = rd_q;
                  end
               end
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pin outputs are registered from the next state so they align with it.
      cs_b_d = !(state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
      oe_b_d = !(state_d == ST_STROBE && !op_we_d);
      we_b_d = !(state_d == ST_STROBE &&  op_we_d);
      ack0_d = (state_d == ST_DONE) && !win_d;
      ack1_d = (state_d == ST_DONE) &&  win_d;
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_we_q  <= 1'b0;
         win_q    <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         rd_q     <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         cs_b_q   <= 1'b1;
         oe_b_q   <= 1'b1;
         we_b_q   <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_we_q  <= op_we_d;
         win_q    <= win_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         rd_q     <= rd_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         cs_b_q   <= cs_b_d;
         oe_b_q   <= oe_b_d;
         we_b_q   <= we_b_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         busy_q   <= busy_d;
      end
   end

   assign ext_RAMCS_b = cs_b_q;
   assign ext_RAMOE_b = oe_b_q;
   assign ext_RAMWE_b = we_b_q;
   assign ext_RAMA    = addr_q;
   assign ext_RAMDin  = din_q;
   assign busy        = busy_q;
   assign p0.ack      = ack0_q;
   assign p1.ack      = ack1_q;
   assign p0.rdata    = rdata0_q;
   assign p1.rdata    = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed table-driven bench for sram_arbiter
module tb_sram_arbiter;

   logic        clk;
   logic        reset_b;
   logic        busy, cs_b, oe_b, we_b;
   logic [17:0] ram_a;
   logic [7:0]  ram_din;
   logic [7:0]  ram_dout;
   logic        busy2, cs2_b, oe2_b, we2_b;
   logic [17:0] ram2_a;
   logic [7:0]  ram2_din;

   int n_chk  = 0;
   int n_pass = 0;

   sram_arbiter_if p0_if ();
   sram_arbiter_if p1_if ();
   sram_arbiter_if q0_if ();
   sram_arbiter_if q1_if ();

   sram_arbiter u_dut (
      .clk         (clk),
      .reset_b     (reset_b),
      .p0          (p0_if),
      .p1          (p1_if),
      .busy        (busy),
      .ext_RAMCS_b (cs_b),
      .ext_RAMOE_b (oe_b),
      .ext_RAMWE_b (we_b),
      .ext_RAMA    (ram_a),
      .ext_RAMDin  (ram_din),
      .ext_RAMDout (ram_dout)
   );

   sram_arbiter #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u_dut2 (
      .clk         (clk),
      .reset_b     (reset_b),
      .p0          (q0_if),
      .p1          (q1_if),
      .busy        (busy2),
      .ext_RAMCS_b (cs2_b),
      .ext_RAMOE_b (oe2_b),
      .ext_RAMWE_b (we2_b),
      .ext_RAMA    (ram2_a),
      .ext_RAMDin  (ram2_din),
      .ext_RAMDout (ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        port;
      logic        we;
      logic [17:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  dout;
      int          exp_we_lo;
      int          exp_oe_lo;
      logic [7:0]  exp_r0;
      logic [7:0]  exp_r1;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_vec(input int i);
      vec_t v;
      int ack_at, acks, other_acks, cs_n, we_n, oe_n, busy_n;
      logic addr_ok, din_ok;
      logic [7:0] r0_ack, r1_ack;
      v = vecs[i];
      ack_at = 0; acks = 0; other_acks = 0; cs_n = 0; we_n = 0; oe_n = 0; busy_n = 0;
      addr_ok = 1'b1; din_ok = 1'b1; r0_ack = 8'hxx; r1_ack = 8'hxx;
      ram_dout = v.dout;
      if (v.port == 1'b0) begin
         p0_if.req = 1'b1; p0_if.we = v.we; p0_if.addr = v.addr; p0_if.wdata = v.wdata;
      end else begin
         p1_if.req = 1'b1; p1_if.we = v.we; p1_if.addr = v.addr; p1_if.wdata = v.wdata;
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (!cs_b) begin
            cs_n++;
            if (ram_a !== v.addr) addr_ok = 1'b0;
            if (v.we && ram_din !== v.wdata) din_ok = 1'b0;
         end
         if (!we_b) we_n++;
         if (!oe_b) oe_n++;
         if (busy) busy_n++;
         if ((v.port ? p1_if.ack : p0_if.ack) === 1'b1) begin
            acks++;
            ack_at = k;
            r0_ack = p0_if.rdata;
            r1_ack = p1_if.rdata;
            p0_if.req = 1'b0;
            p1_if.req = 1'b0;
         end
         if ((v.port ? p0_if.ack : p1_if.ack) === 1'b1) other_acks++;
      end
      chk($sformatf("v%0d_ack_cycle", i), ack_at, 5);
      chk($sformatf("v%0d_ack_count", i), acks, 1);
      chk($sformatf("v%0d_other_ack", i), other_acks, 0);
      chk($sformatf("v%0d_cs_low", i), cs_n, 4);
      chk($sformatf("v%0d_busy", i), busy_n, 5);
      chk($sformatf("v%0d_we_low", i), we_n, v.exp_we_lo);
      chk($sformatf("v%0d_oe_low", i), oe_n, v.exp_oe_lo);
      chk($sformatf("v%0d_addr_stable", i), addr_ok, 1);
      chk($sformatf("v%0d_din_stable", i), din_ok, 1);
      chk($sformatf("v%0d_rdata0_at_ack", i), r0_ack, v.exp_r0);
      chk($sformatf("v%0d_rdata1_at_ack", i), r1_ack, v.exp_r1);
      chk($sformatf("v%0d_rdata0_held", i), p0_if.rdata, v.exp_r0);
      chk($sformatf("v%0d_rdata1_held", i), p1_if.rdata, v.exp_r1);
   endtask

   initial begin
      int p0_acks, p1_acks, first_ack, last_ack, prev_ack, gaps_ok, p1_last;
      int acks, ack_at, we_n, cs_n;

      vecs[0] = '{1'b0, 1'b1, 18'h12345, 8'h5A, 8'h99, 2, 0, 8'h00, 8'h00};
      vecs[1] = '{1'b1, 1'b0, 18'h3FFFF, 8'h00, 8'hA7, 0, 2, 8'h00, 8'hA7};
      vecs[2] = '{1'b0, 1'b0, 18'h00000, 8'h11, 8'h3C, 0, 2, 8'h3C, 8'hA7};
      vecs[3] = '{1'b1, 1'b1, 18'h3FFFF, 8'hFF, 8'h66, 2, 0, 8'h3C, 8'hA7};
      vecs[4] = '{1'b0, 1'b1, 18'h20001, 8'h00, 8'hEE, 2, 0, 8'h3C, 8'hA7};
      vecs[5] = '{1'b1, 1'b0, 18'h15555, 8'h22, 8'h81, 0, 2, 8'h3C, 8'h81};

      reset_b = 1'b0;
      ram_dout = 8'h00;
      p0_if.req = 0; p0_if.we = 0; p0_if.addr = '0; p0_if.wdata = '0;
      p1_if.req = 0; p1_if.we = 0; p1_if.addr = '0; p1_if.wdata = '0;
      q0_if.req = 0; q0_if.we = 0; q0_if.addr = '0; q0_if.wdata = '0;
      q1_if.req = 0; q1_if.we = 0; q1_if.addr = '0; q1_if.wdata = '0;
      repeat (3) tick();

      chk("rst_cs", cs_b, 1);
      chk("rst_oe", oe_b, 1);
      chk("rst_we", we_b, 1);
      chk("rst_addr", ram_a, 0);
      chk("rst_din", ram_din, 0);
      chk("rst_acks", {p0_if.ack, p1_if.ack}, 0);
      chk("rst_rdata", {p0_if.rdata, p1_if.rdata}, 0);
      chk("rst_busy", busy, 0);
      reset_b = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         do_vec(i);
      end

      // Both ports requesting continuously; port 1 left alone from cycle 24.
      p0_acks = 0; p1_acks = 0; first_ack = 0; last_ack = 0; prev_ack = 0; gaps_ok = 1; p1_last = 0;
      p0_if.req = 1; p0_if.we = 1; p0_if.addr = 18'h00100; p0_if.wdata = 8'hC3;
      p1_if.req = 1; p1_if.we = 0; p1_if.addr = 18'h00200;
      for (int k = 1; k <= 32; k++) begin
         tick();
         if (p0_if.ack === 1'b1 || p1_if.ack === 1'b1) begin
            if (first_ack == 0) first_ack = k;
            if (k <= 24 && prev_ack != 0 && k - prev_ack != 6) gaps_ok = 0;
            if (k <= 24) last_ack = k;
            prev_ack = k;
         end
         if (p0_if.ack === 1'b1) p0_acks++;
         if (p1_if.ack === 1'b1) begin
            p1_acks++;
            p1_last = k;
            if (k > 24) p1_if.req = 0;
         end
         if (k == 24) p0_if.req = 0;
      end
      chk("both_first_ack", first_ack, 5);
      chk("both_last_ack", last_ack, 23);
      chk("both_gap6", gaps_ok, 1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      chk("both_p0_acks", p0_acks, 2);
      chk("both_p1_acks", p1_acks, 3);
`else
      chk("both_p0_acks", p0_acks, 4);
      chk("both_p1_acks", p1_acks, 1);
`endif
      chk("pending_p1_ack", p1_last, 29);
      chk("both_idle_busy", busy, 0);

      // Request dropped during SETUP still completes.
      acks = 0; ack_at = 0;
      p0_if.req = 1; p0_if.we = 1; p0_if.addr = 18'h0F0F0; p0_if.wdata = 8'h77;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) begin
            chk("drop_setup_cs", cs_b, 0);
            p0_if.req = 0;
         end
         if (p0_if.ack === 1'b1) begin
            acks++;
            ack_at = k;
         end
      end
      chk("drop_ack_count", acks, 1);
      chk("drop_ack_cycle", ack_at, 5);

      // Parameterised timing 3/1/2.
      acks = 0; ack_at = 0; we_n = 0; cs_n = 0;
      q0_if.req = 1; q0_if.we = 1; q0_if.addr = 18'h0ABCD; q0_if.wdata = 8'h11;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (!cs2_b) cs_n++;
         if (!we2_b) we_n++;
         if (q0_if.ack === 1'b1) begin
            acks++;
            ack_at = k;
            q0_if.req = 0;
         end
      end
      chk("p312_ack_cycle", ack_at, 7);
      chk("p312_ack_count", acks, 1);
      chk("p312_we_low", we_n, 1);
      chk("p312_cs_low", cs_n, 6);
      chk("p312_oe", oe2_b, 1);

      // Reset asserted while the write strobe is active.
      acks = 0;
      p0_if.req = 1; p0_if.we = 1; p0_if.addr = 18'h01234; p0_if.wdata = 8'hAB;
      tick();
      tick();
      chk("rst_mid_we_before", we_b, 0);
      reset_b = 1'b0;
      #1;
      chk("rst_mid_we_after", we_b, 1);
      chk("rst_mid_cs_after", cs_b, 1);
      p0_if.req = 0;
      tick();
      tick();
      reset_b = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (p0_if.ack === 1'b1 || p1_if.ack === 1'b1) acks++;
      end
      chk("rst_mid_no_ack", acks, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cs_idle", cs_b, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the 256K x 8 external SRAM. Takes single-byte read/write requests from two requesters (port 0: CP/M Z80 memory interface; port 1: loader/DMA engine), grants one at a time, and drives the SRAM strobes with programmable setup/strobe/hold timing. Sits between the requesters and the SRAM pins, replacing direct strobe pass-through.

## Interface
Parameters:
- SETUP_CYC, 1, cycles with CS low and address/data valid before the strobe (legal 1..7)
- STROBE_CYC, 2, cycles WE_b or OE_b held low (legal 1..7)
- HOLD_CYC, 1, cycles after strobe release with CS low, address/data held (legal 1..7)

Ports:
- clk  in  1  system clock, single clock domain
- reset_b  in  1  asynchronous, active-low reset
- p0_req / p1_req  in  1  request; held high with fields stable until ack
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  18  byte address
- p0_wdata / p1_wdata  in  8  write data
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  8  read data; valid with ack, held until next read completes on that port
- busy  out  1  high whenever state is not IDLE
- ext_RAMCS_b, ext_RAMOE_b, ext_RAMWE_b  out  1  SRAM strobes, active low
- ext_RAMA  out  18  SRAM address
- ext_RAMDin  out  8  write data to SRAM
- ext_RAMDout  in  8  read data from SRAM

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE. All outputs registered.
- IDLE: CS_b/OE_b/WE_b = 1. If any req high, pick winner, latch its we/addr/wdata into ext_RAMA/ext_RAMDin and an internal op register, go SETUP.
- SETUP: CS_b = 0, OE_b = WE_b = 1 for SETUP_CYC cycles -> STROBE.
- STROBE: CS_b = 0; WE_b = 0 (write) or OE_b = 0 (read) for STROBE_CYC cycles. Read: ext_RAMDout captured on the clock edge ending the final STROBE cycle -> HOLD.
- HOLD: strobes high, CS_b = 0, address/data unchanged, HOLD_CYC cycles -> DONE.
- DONE: CS_b = 1; winner's ack = 1 and (read) its rdata updated; -> IDLE unconditionally.
- Arbitration: fixed priority, port 0 wins simultaneous requests (see Configuration).
- One 3-bit down-counter shared across SETUP/STROBE/HOLD, loaded with PARAM-1 on entry.
- Request dropped mid-access: access still completes, ack still pulsed.
- Non-winning request stays pending, unaffected.

## Timing
- Reset values: ext_RAMCS_b/OE_b/WE_b = 1, ext_RAMA = 0, ext_RAMDin = 0, acks = 0, rdata = 0, busy = 0, state IDLE, last-grant = port 1.
- reset_b low mid-access: strobes forced high asynchronously, access aborted, no ack.
- Request sampled high in IDLE at cycle N: SETUP from N+1, ack high in cycle N+1+SETUP_CYC+STROBE_CYC+HOLD_CYC (defaults: N+5).
- Requester may change fields/deassert on the edge ending the ack cycle; the following IDLE cycle samples afresh. Back-to-back throughput: one access per 2+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (defaults 6).
- Address/data never change while CS_b = 0.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: simultaneous requests granted to the port not granted last; last-grant register updated in IDLE on each grant.
- Undefined: fixed priority to port 0; last-grant register not built.

## Structure
- Package sram_arb_pkg: state enum, SRAM_AW = 18, SRAM_DW = 8, counter width constant.
- Sub-module sram_arb_select: combinational winner pick from {p0_req, p1_req, last_grant}, macro-dependent.

## Test plan
- Port 0 write 0x5A to 0x12345, defaults -> WE_b low exactly 2 cycles, CS_b low 4 cycles, p0_ack at N+5, address stable throughout.
- Port 1 read of 0x3FFFF with ext_RAMDout = 0xA7 -> OE_b low 2 cycles, p1_rdata = 0xA7 with p1_ack at N+5, held afterwards.
- Both req high continuously -> fixed: port 0 served repeatedly; RR: grants alternate 0,1,0,1, one ack every 6 cycles.
- SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2 -> ack at N+7, WE_b low 1 cycle.
- reset_b low during STROBE -> strobes high immediately, no ack, state IDLE after release.
- p0_req dropped during SETUP -> access completes, p0_ack still pulsed.
